chacha_host: RTL and testbench
==============================

// Module: chacha_host
// PURPOSE
//  Host-side sequencer for the ChaCha block core: the initiator of the core's write/ready/read byte protocol.
//  Per 64-byte block it writes the 16-word input state, waits for ready, then reads 64 keystream bytes.
//  Each keystream byte is XORed with one message byte and the result is emitted on a valid/ready stream.
//  Block counter auto-increments; sits between the message datapath and the block core.
// PARAMETERS
//  (none; widths fixed by the ChaCha20 state: 256b key, 96b nonce, 32b counter)
// PORTS
//  clk         in   1    clock
//  rst_n       in   1    synchronous, active-low reset; shared with the core
//  key         in   256  key; word j = key[32j+31:32j]; sampled on start
//  nonce       in   96   nonce; word j = nonce[32j+31:32j]; sampled on start
//  ctr_init    in   32   initial block counter; sampled on start
//  start       in   1    1-cycle pulse; accepted only in IDLE
//  busy        out  1    high in every state except IDLE
//  done        out  1    1-cycle pulse: last message byte's output accepted
//  msg_data    in   8    message byte
//  msg_valid   in   1    msg_data valid
//  msg_last    in   1    marks final message byte (with msg_valid)
//  msg_ready   out  1    message byte consumed this cycle
//  out_data    out  8    msg_data ^ keystream, registered
//  out_valid   out  1    out_data valid
//  out_last    out  1    out_data is final byte
//  out_ready   in   1    downstream accepts out_data
//  core_data   out  8    byte to core data_in
//  core_write  out  1    core write strobe; one byte per asserted cycle
//  core_read   out  1    core read strobe; core_ks valid same cycle, core advances on clk
//  core_ks     in   8    keystream byte from core data_out
//  core_ready  in   1    core ready
// BEHAVIOUR
//  Reset: FSM=IDLE; busy,done,msg_ready,out_valid,out_last,core_write,core_read=0; out_data,core_data=0; idx=0.
//  State byte b (0..63) = word[b>>2] bits [8(b&3)+7:8(b&3)] (little-endian).
//  Words 0-3 = 0x61707865,0x3320646e,0x79622d32,0x6b206574; 4-11 key; 12 ctr; 13-15 nonce.
//  IDLE: start -> latch key/nonce/ctr_init, idx=0, -> LOAD. start outside IDLE ignored.
//  LOAD: core_write=1 for 64 consecutive cycles, core_data=byte idx; after idx 63 -> WAIT.
//  WAIT: first cycle ignores core_ready (core state settling); afterwards core_ready=1 -> STREAM, idx=0.
//  STREAM: fire = msg_valid & (!out_valid | out_ready).
//   fire -> core_read=1, msg_ready=1, out_data<=msg_data^core_ks, out_valid<=1, out_last<=msg_last, idx++.
//   fire & msg_last & idx<63 -> DRAIN. fire & msg_last & idx==63 -> FLUSH.
//   fire & !msg_last & idx==63 -> ctr<=ctr+1, idx=0, -> LOAD.
//  DRAIN: core_read=1 every cycle, ks discarded, until 64 reads total this block -> FLUSH.
//   Keeps the core's byte address aligned to 0 for the next block.
//  FLUSH: wait for out_valid & out_ready on the last byte; done=1 that cycle -> IDLE.
//  out_valid clears on out_ready unless a new fire in the same cycle (simultaneous accept+refill allowed).
//  Throughput: 1 byte/cycle in STREAM; per-block overhead = 64 LOAD + WAIT cycles.
//  core_write and core_read never high together; neither high outside LOAD/STREAM/DRAIN.
//  ctr wraps 0xFFFFFFFF -> 0x00000000 modulo 2^32 (see CONFIGURATION).
//  Reset mid-operation: all state discarded, same values as above; the core resets on the same rst_n.
// CONFIGURATION
//  CHACHA_HOST_CTR_WRAP_ERR_EN defined: extra output port ctr_err (1b, reset 0).
//   Increment from 0xFFFFFFFF sets ctr_err=1, aborts to IDLE without LOAD; no done pulse.
//   ctr_err is sticky until the next accepted start.
//  Not defined: no ctr_err port; silent modulo-2^32 wrap, streaming continues.
// STRUCTURE
//  Shared package chacha_pkg: SIGMA0..3 constants, FSM state encoding, BLOCK_BYTES=64.
//  Sub-module chacha_state_mux: combinational idx[5:0] + key/nonce/ctr -> state byte.
//  FSM, counters and output register stay in chacha_host.
// TESTING
//  RFC 8439 2.4.2 vector (key 00..1f, nonce 000000000000004a00000000, ctr=1), 114-byte plaintext -> ciphertext matches RFC; done once.
//  Single byte msg_last: 1 output byte, then 63 DRAIN reads; next start's first core_data=0x65.
//  out_ready toggled randomly, msg_valid gaps -> no byte lost or duplicated; core_read count == fires + drains.
//  Exactly 128 bytes -> two LOADs, second word 12 = ctr_init+1; ends via FLUSH with no DRAIN.
//  rst_n low mid-STREAM -> all outputs at reset values next cycle; fresh start gives correct output.
//  ctr_init=0xFFFFFFFF, 65 bytes -> with _EN ctr_err=1 and IDLE after 64 bytes; without, block 2 uses ctr=0.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha host sequencer: block geometry, the
// ChaCha "expand 32-byte k" constants, host FSM encoding and the helper that
// lays out the 16-word input state.
package chacha_pkg;

  localparam int unsigned BLOCK_BYTES = 64;
  localparam logic [5:0]  LAST_IDX    = 6'(BLOCK_BYTES - 1);

  localparam logic [31:0] SIGMA0 = 32'h6170_7865;
  localparam logic [31:0] SIGMA1 = 32'h3320_646e;
  localparam logic [31:0] SIGMA2 = 32'h7962_2d32;
  localparam logic [31:0] SIGMA3 = 32'h6b20_6574;

  // Byte 0 of every block is the low byte of SIGMA0, independent of key/ctr.
  localparam logic [7:0]  FIRST_STATE_BYTE = SIGMA0[7:0];

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_FLUSH  = 3'd5
  } host_state_t;

  // 16-word input state; word j occupies bits [32j+31:32j], so byte b sits
  // at bits [8b+7:8b] (little-endian words).
  function automatic logic [511:0] pack_state(input logic [255:0] key,
                                              input logic [31:0]  ctr,
                                              input logic [95:0]  nonce);
    return {nonce, ctr, key, SIGMA3, SIGMA2, SIGMA1, SIGMA0};
  endfunction

endpackage

// File: rtl/chacha_state_mux.sv
// Combinational byte selector over the ChaCha input state: returns state
// byte idx (0..63) built from the constants, key, block counter and nonce.
module chacha_state_mux
  import chacha_pkg::*;
(
  input  logic [5:0]   idx,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  ctr,
  output logic [7:0]   state_byte
);

  logic [511:0] state_s;

  // Flatten the state and pick the addressed little-endian byte
  always_comb begin
    state_s    = pack_state(key, ctr, nonce);
    state_byte = state_s[{idx, 3'b000} +: 8];
  end

endmodule

// File: rtl/chacha_host.sv
// Host-side sequencer for the ChaCha block core. Per 64-byte block it writes
// the input state byte by byte, waits for the core, then reads keystream bytes
// one per accepted message byte and emits message ^ keystream on a
// valid/ready stream. The block counter advances automatically.
// Optional build macro CHACHA_HOST_CTR_WRAP_ERR_EN adds a sticky ctr_err
// output and aborts instead of wrapping the block counter past 0xFFFFFFFF.
module chacha_host
  import chacha_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  ctr_init,
  input  logic         start,
  output logic         busy,
  output logic         done,
  input  logic [7:0]   msg_data,
  input  logic         msg_valid,
  input  logic         msg_last,
  output logic         msg_ready,
  output logic [7:0]   out_data,
  output logic         out_valid,
  output logic         out_last,
  input  logic         out_ready,
  output logic [7:0]   core_data,
  output logic         core_write,
  output logic         core_read,
  input  logic [7:0]   core_ks,
  input  logic         core_ready
`ifdef CHACHA_HOST_CTR_WRAP_ERR_EN
  ,
  output logic         ctr_err
`endif
);

  host_state_t  state_r;
  logic [5:0]   idx_r;
  logic [255:0] key_r;
  logic [95:0]  nonce_r;
  logic [31:0]  ctr_r;

  logic [5:0]   mux_idx_s;
  logic [7:0]   mux_byte_s;
  logic         last_idx_s;
  logic         fire_s;

  // core_data is registered, so the mux always looks one byte ahead
  chacha_state_mux u_state_mux (
    .idx        (mux_idx_s),
    .key        (key_r),
    .nonce      (nonce_r),
    .ctr        (ctr_r),
    .state_byte (mux_byte_s)
  );

  // Handshake terms that must follow this cycle's stream inputs
  always_comb begin
    mux_idx_s  = idx_r + 6'd1;
    last_idx_s = (idx_r == LAST_IDX);
    fire_s     = (state_r == ST_STREAM) && msg_valid && (!out_valid || out_ready);
    msg_ready  = fire_s;
    core_read  = fire_s || (state_r == ST_DRAIN);
    busy       = (state_r != ST_IDLE);
    // Last byte leaves the output register; may land in DRAIN or FLUSH.
    done       = out_valid && out_ready && out_last;
  end

  // Output register: load on fire, otherwise clear once downstream takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (fire_s) begin
      out_data  <= msg_data ^ core_ks;
      out_valid <= 1'b1;
      out_last  <= msg_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

  // Block sequencing FSM: load state, wait for core, stream, drain, flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      idx_r      <= 6'd0;
      key_r      <= 256'd0;
      nonce_r    <= 96'd0;
      ctr_r      <= 32'd0;
      core_write <= 1'b0;
      core_data  <= 8'h00;
`ifdef CHACHA_HOST_CTR_WRAP_ERR_EN
      ctr_err    <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            key_r      <= key;
            nonce_r    <= nonce;
            ctr_r      <= ctr_init;
            idx_r      <= 6'd0;
            core_write <= 1'b1;
            core_data  <= FIRST_STATE_BYTE;
            state_r    <= ST_LOAD;
`ifdef CHACHA_HOST_CTR_WRAP_ERR_EN
            ctr_err    <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          // idx wraps 63 -> 0, which is the WAIT settle marker
          idx_r <= mux_idx_s;
          if (last_idx_s) begin
            core_write <= 1'b0;
            core_data  <= 8'h00;
            state_r    <= ST_WAIT;
          end else begin
            core_data  <= mux_byte_s;
          end
        end
        ST_WAIT: begin
          // idx 0 marks the first WAIT cycle, where core_ready is stale
          if (idx_r == 6'd0) begin
            idx_r <= 6'd1;
          end else if (core_ready) begin
            idx_r   <= 6'd0;
            state_r <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (fire_s) begin
            idx_r <= mux_idx_s;
            if (msg_last) begin
              state_r <= last_idx_s ? ST_FLUSH : ST_DRAIN;
            end else if (last_idx_s) begin
`ifdef CHACHA_HOST_CTR_WRAP_ERR_EN
              if (ctr_r == 32'hFFFF_FFFF) begin
                ctr_err <= 1'b1;
                state_r <= ST_IDLE;
              end else begin
                ctr_r      <= ctr_r + 32'd1;
                core_write <= 1'b1;
                core_data  <= FIRST_STATE_BYTE;
                state_r    <= ST_LOAD;
              end
`else
              ctr_r      <= ctr_r + 32'd1;
              core_write <= 1'b1;
              core_data  <= FIRST_STATE_BYTE;
              state_r    <= ST_LOAD;
`endif
            end
          end
        end
        ST_DRAIN: begin
          // Finish the block's 64 reads so the core restarts at byte 0
          idx_r <= mux_idx_s;
          if (last_idx_s) begin
            state_r <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // Last byte may already have gone during DRAIN
          if (!out_valid || out_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_host.sv
// Self-checking bench for chacha_host. A behavioural ChaCha20 block core
// answers the write/ready/read protocol; expected ciphertext comes from the
// RFC 8439 2.4.2 table or from a reference ChaCha20 function over the state
// the bench builds itself from key/nonce/counter.
module tb_chacha_host;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  ctr_init;
  logic         start;
  logic         busy, done;
  logic [7:0]   msg_data;
  logic         msg_valid, msg_last, msg_ready;
  logic [7:0]   out_data;
  logic         out_valid, out_last, out_ready;
  logic [7:0]   core_data;
  logic         core_write, core_read;
  logic [7:0]   core_ks;
  logic         core_ready;
`ifdef CHACHA_HOST_CTR_WRAP_ERR_EN
  logic         ctr_err;
`endif

  always #5 clk = ~clk;

  chacha_host dut (
    .clk(clk), .rst_n(rst_n), .key(key), .nonce(nonce), .ctr_init(ctr_init),
    .start(start), .busy(busy), .done(done),
    .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .core_data(core_data), .core_write(core_write), .core_read(core_read),
    .core_ks(core_ks), .core_ready(core_ready)
`ifdef CHACHA_HOST_CTR_WRAP_ERR_EN
    , .ctr_err(ctr_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference ChaCha20 ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] chacha_block(input logic [511:0] s);
    logic [31:0] x [16];
    logic [31:0] a, b, c, d;
    logic [511:0] r;
    int qa [8]; int qb [8]; int qc [8]; int qd [8];
    qa = '{0, 1, 2, 3, 0, 1, 2, 3};
    qb = '{4, 5, 6, 7, 5, 6, 7, 4};
    qc = '{8, 9, 10, 11, 10, 11, 8, 9};
    qd = '{12, 13, 14, 15, 15, 12, 13, 14};
    for (int j = 0; j < 16; j++) x[j] = s[32*j +: 32];
    for (int rnd = 0; rnd < 10; rnd++) begin
      for (int q = 0; q < 8; q++) begin
        a = x[qa[q]]; b = x[qb[q]]; c = x[qc[q]]; d = x[qd[q]];
        a = a + b; d = rotl(d ^ a, 16);
        c = c + d; b = rotl(b ^ c, 12);
        a = a + b; d = rotl(d ^ a, 8);
        c = c + d; b = rotl(b ^ c, 7);
        x[qa[q]] = a; x[qb[q]] = b; x[qc[q]] = c; x[qd[q]] = d;
      end
    end
    for (int j = 0; j < 16; j++) r[32*j +: 32] = x[j] + s[32*j +: 32];
    return r;
  endfunction

  function automatic logic [511:0] exp_state(input logic [255:0] k, input logic [95:0] n,
                                             input logic [31:0] c);
    return {n, c, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
  endfunction

  function automatic logic [7:0] exp_ks(input logic [255:0] k, input logic [95:0] n,
                                        input logic [31:0] c, input int i);
    logic [511:0] blk;
    blk = chacha_block(exp_state(k, n, c + 32'(i / 64)));
    return blk[8*(i % 64) +: 8];
  endfunction

  // ---------------- behavioural block core ----------------
  logic [511:0] cst_m = '0;
  logic [511:0] ks_m  = '0;
  logic [5:0]   wr_ptr_m, rd_ptr_m;
  int           lat_m;
  logic         ready_m;
  int           rd_total = 0;
  int           ld_cnt   = 0;
  int           viol_rw  = 0;
  int           viol_rd  = 0;
  logic [511:0] loaded [8];

  assign core_ks    = ks_m[{rd_ptr_m, 3'b000} +: 8];
  assign core_ready = ready_m;

  // Core model: collect 64 writes, compute after a short latency, serve reads
  always @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_m <= 6'd0;
      rd_ptr_m <= 6'd0;
      lat_m    <= 0;
      ready_m  <= 1'b0;
    end else begin
      if (core_write) begin
        cst_m[{wr_ptr_m, 3'b000} +: 8] <= core_data;
        wr_ptr_m <= wr_ptr_m + 6'd1;
        ready_m  <= 1'b0;
        if (wr_ptr_m == 6'd63) begin
          lat_m              <= 3;
          loaded[ld_cnt % 8] <= {core_data, cst_m[503:0]};
          ld_cnt             <= ld_cnt + 1;
        end
      end else if (lat_m > 1) begin
        lat_m <= lat_m - 1;
      end else if (lat_m == 1) begin
        ks_m    <= chacha_block(cst_m);
        ready_m <= 1'b1;
        lat_m   <= 0;
      end
      if (core_read) begin
        rd_ptr_m <= rd_ptr_m + 6'd1;
        rd_total <= rd_total + 1;
        if (!ready_m) viol_rd <= viol_rd + 1;
      end
      if (core_write && core_read) viol_rw <= viol_rw + 1;
    end
  end

  // ---------------- stream plumbing ----------------
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  logic       rx_last_q [$];
  int         done_cnt;

  localparam string RFC_PT =
    "Ladies and Gentlemen of the class of '99: If I could offer you only one tip for the future, sunscreen would be it.";
  localparam logic [911:0] RFC_CT = {
    128'h6e2e359a2568f98041ba0728dd0d6981,
    128'he97e7aec1d4360c20a27afccfd9fae0b,
    128'hf91b65c5524733ab8f593dabcd62b357,
    128'h1639d624e65152ab8f530c359f0861d8,
    128'h07ca0dbf500d6a6156a38e088a22b65e,
    128'h52bc514d16ccf806818ce91ab7793736,
    128'h5af90bbf74a35be6b40b8eedf2785e42,
    16'h874d};

  task automatic clear_bufs();
    tx_q.delete(); rx_q.delete(); rx_last_q.delete(); done_cnt = 0;
  endtask

  task automatic do_start(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c);
    @(negedge clk);
    key = k; nonce = n; ctr_init = c; start = 1'b1;
    msg_valid = 1'b0; msg_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    checks++;
    if (core_write !== 1'b1 || core_data !== 8'h65) begin
      errors++;
      $display("FAIL first_load: write=%b data=%h, want write=1 data=65", core_write, core_data);
    end
`ifdef CHACHA_HOST_CTR_WRAP_ERR_EN
    checks++;
    if (ctr_err !== 1'b0) begin errors++; $display("FAIL ctr_err_clear: got %b want 0", ctr_err); end
`endif
  endtask

  task automatic run_stream(input int n, input int ready_pct, input int gap_pct,
                            input int max_cyc, output bit timed_out);
    int sent;
    sent = 0;
    timed_out = 1'b1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      msg_valid = (sent < n) && ($urandom_range(0, 99) >= gap_pct);
      msg_data  = (sent < n) ? tx_q[sent] : 8'h00;
      msg_last  = (sent == n - 1);
      out_ready = ($urandom_range(0, 99) < ready_pct);
      #1;
      if (msg_ready) sent++;
      if (out_valid && out_ready) begin
        rx_q.push_back(out_data);
        rx_last_q.push_back(out_last);
      end
      if (done) done_cnt++;
      if (!busy && !out_valid) begin
        timed_out = 1'b0;
        break;
      end
    end
    msg_valid = 1'b0; msg_last = 1'b0; out_ready = 1'b0;
  endtask

  function automatic int stream_bad(input logic [255:0] k, input logic [95:0] n,
                                    input logic [31:0] c, input int nb, input bit has_last);
    int bad;
    bad = 0;
    if (rx_q.size() != nb) return 1000 + rx_q.size();
    for (int i = 0; i < nb; i++) begin
      if (rx_q[i] !== (tx_q[i] ^ exp_ks(k, n, c, i))) bad++;
      if (rx_last_q[i] !== (has_last && (i == nb - 1))) bad++;
    end
    return bad;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; key = '0; nonce = '0; ctr_init = '0;
    msg_data = 8'h00; msg_valid = 1'b0; msg_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, msg_ready, out_valid, out_last, core_write, core_read} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {busy, done, msg_ready, out_valid, out_last, core_write, core_read});
    end
    checks++;
    if ({out_data, core_data} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h want 0000", {out_data, core_data});
    end
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b want 0", busy); end
`ifdef CHACHA_HOST_CTR_WRAP_ERR_EN
    checks++;
    if (ctr_err !== 1'b0) begin errors++; $display("FAIL reset_ctr_err: got %b want 0", ctr_err); end
`endif
  endtask

  task automatic test_rfc();
    logic [255:0] k; int rd0, ld0, bad; bit to;
    for (int b = 0; b < 32; b++) k[8*b +: 8] = 8'(b);
    clear_bufs();
    for (int i = 0; i < 114; i++) tx_q.push_back(RFC_PT[i]);
    rd0 = rd_total; ld0 = ld_cnt;
    do_start(k, 96'h00000000_4a000000_00000000, 32'd1);
    run_stream(114, 100, 0, 3000, to);
    checks++; if (to) begin errors++; $display("FAIL rfc_timeout: no return to idle"); end
    bad = 0;
    if (rx_q.size() != 114) bad = 1000 + rx_q.size();
    else for (int i = 0; i < 114; i++) if (rx_q[i] !== RFC_CT[911 - 8*i -: 8]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rfc_ciphertext: %0d bad bytes, want 0", bad); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rfc_done: got %0d pulses want 1", done_cnt); end
    checks++; if (rd_total - rd0 != 128) begin errors++; $display("FAIL rfc_reads: got %0d want 128", rd_total - rd0); end
    checks++; if (ld_cnt - ld0 != 2) begin errors++; $display("FAIL rfc_loads: got %0d want 2", ld_cnt - ld0); end
    checks++;
    if (loaded[ld0 % 8][415:384] !== 32'd1 || loaded[(ld0 + 1) % 8][415:384] !== 32'd2) begin
      errors++;
      $display("FAIL rfc_ctr_words: got %h,%h want 00000001,00000002",
               loaded[ld0 % 8][415:384], loaded[(ld0 + 1) % 8][415:384]);
    end
  endtask

  task automatic test_single_byte();
    logic [255:0] k; logic [95:0] n; int rd0; bit to;
    k = {8{32'hdead_beef}}; n = 96'h0102_0304_0506_0708_090a_0b0c;
    clear_bufs(); tx_q.push_back(8'h3c);
    rd0 = rd_total;
    do_start(k, n, 32'd5);
    run_stream(1, 100, 0, 500, to);
    checks++; if (to) begin errors++; $display("FAIL single_timeout: no return to idle"); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== (8'h3c ^ exp_ks(k, n, 32'd5, 0))) begin
      errors++;
      $display("FAIL single_data: got %0d bytes first=%h want 1 byte %h",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, 8'h3c ^ exp_ks(k, n, 32'd5, 0));
    end
    checks++;
    if (rx_q.size() == 1 && rx_last_q[0] !== 1'b1) begin errors++; $display("FAIL single_last: got 0 want 1"); end
    checks++; if (rd_total - rd0 != 64) begin errors++; $display("FAIL single_drain_reads: got %0d want 64", rd_total - rd0); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_random_flow();
    logic [255:0] k; logic [95:0] n; int rd0, bad; bit to;
    k = 256'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_01234567_89abcdef_fedcba98_76543210;
    n = 96'hcafe_f00d_1234_5678_9abc_def0;
    clear_bufs();
    for (int i = 0; i < 150; i++) tx_q.push_back(8'($urandom));
    rd0 = rd_total;
    do_start(k, n, 32'h0000_0100);
    run_stream(150, 50, 30, 5000, to);
    checks++; if (to) begin errors++; $display("FAIL random_timeout: no return to idle"); end
    bad = stream_bad(k, n, 32'h0000_0100, 150, 1'b1);
    checks++; if (bad != 0) begin errors++; $display("FAIL random_data: %0d bad, want 0", bad); end
    checks++; if (rd_total - rd0 != 192) begin errors++; $display("FAIL random_reads: got %0d want 192", rd_total - rd0); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL random_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_two_blocks();
    logic [255:0] k; logic [95:0] n; int rd0, ld0, bad; bit to;
    k = {16{16'h5aa5}}; n = 96'h1111_2222_3333_4444_5555_6666;
    clear_bufs();
    for (int i = 0; i < 128; i++) tx_q.push_back(8'(i * 3));
    rd0 = rd_total; ld0 = ld_cnt;
    do_start(k, n, 32'h0000_0007);
    run_stream(128, 100, 0, 3000, to);
    checks++; if (to) begin errors++; $display("FAIL two_timeout: no return to idle"); end
    bad = stream_bad(k, n, 32'h0000_0007, 128, 1'b1);
    checks++; if (bad != 0) begin errors++; $display("FAIL two_data: %0d bad, want 0", bad); end
    checks++; if (ld_cnt - ld0 != 2) begin errors++; $display("FAIL two_loads: got %0d want 2", ld_cnt - ld0); end
    checks++;
    if (loaded[(ld0 + 1) % 8][415:384] !== 32'h0000_0008) begin
      errors++;
      $display("FAIL two_ctr_word: got %h want 00000008", loaded[(ld0 + 1) % 8][415:384]);
    end
    checks++; if (rd_total - rd0 != 128) begin errors++; $display("FAIL two_reads_no_drain: got %0d want 128", rd_total - rd0); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL two_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] k; logic [95:0] n; int fired, bad; bit to;
    k = {4{64'h0123_4567_89ab_cdef}}; n = 96'h0;
    do_start(k, n, 32'd3);
    fired = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      msg_valid = 1'b1; msg_data = 8'(cyc); msg_last = 1'b0; out_ready = 1'b1;
      #1;
      if (msg_ready) fired++;
    end
    checks++; if (fired == 0) begin errors++; $display("FAIL mid_reached_stream: got 0 fires want >0"); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({busy, done, msg_ready, out_valid, out_last, core_write, core_read} !== 7'b0 ||
        {out_data, core_data} !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_outputs: ctrl=%b data=%h want 0",
               {busy, done, msg_ready, out_valid, out_last, core_write, core_read},
               {out_data, core_data});
    end
    rst_n = 1'b1; msg_valid = 1'b0; out_ready = 1'b0;
    clear_bufs();
    for (int i = 0; i < 20; i++) tx_q.push_back(8'(8'hA0 + i));
    do_start(k, n, 32'd9);
    run_stream(20, 80, 10, 2000, to);
    checks++; if (to) begin errors++; $display("FAIL mid_restart_timeout: no return to idle"); end
    bad = stream_bad(k, n, 32'd9, 20, 1'b1);
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_restart_data: %0d bad, want 0", bad); end
  endtask

  task automatic test_ctr_wrap();
    logic [255:0] k; logic [95:0] n; int ld0, rd0, bad; bit to;
    k = {8{32'h7777_0001}}; n = 96'habcd_ef01_2345_6789_0000_0001;
    clear_bufs();
    for (int i = 0; i < 65; i++) tx_q.push_back(8'(255 - i));
    ld0 = ld_cnt; rd0 = rd_total;
    do_start(k, n, 32'hFFFF_FFFF);
    run_stream(65, 100, 0, 3000, to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout: no return to idle"); end
`ifdef CHACHA_HOST_CTR_WRAP_ERR_EN
    bad = stream_bad(k, n, 32'hFFFF_FFFF, 64, 1'b0);
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_err_data: %0d bad, want 0", bad); end
    checks++; if (ctr_err !== 1'b1) begin errors++; $display("FAIL wrap_ctr_err: got %b want 1", ctr_err); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL wrap_err_done: got %0d want 0", done_cnt); end
    checks++; if (ld_cnt - ld0 != 1) begin errors++; $display("FAIL wrap_err_loads: got %0d want 1", ld_cnt - ld0); end
    checks++; if (rd_total - rd0 != 64) begin errors++; $display("FAIL wrap_err_reads: got %0d want 64", rd_total - rd0); end
    // A fresh start must clear the sticky flag (checked inside do_start).
    clear_bufs();
    for (int i = 0; i < 3; i++) tx_q.push_back(8'(i));
    do_start(k, n, 32'd0);
    run_stream(3, 100, 0, 500, to);
    bad = stream_bad(k, n, 32'd0, 3, 1'b1);
    checks++;
    if (to || bad != 0) begin errors++; $display("FAIL wrap_err_recover: timeout=%0d bad=%0d want 0", to, bad); end
`else
    bad = stream_bad(k, n, 32'hFFFF_FFFF, 65, 1'b1);
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_data: %0d bad, want 0", bad); end
    checks++; if (ld_cnt - ld0 != 2) begin errors++; $display("FAIL wrap_loads: got %0d want 2", ld_cnt - ld0); end
    checks++;
    if (loaded[(ld0 + 1) % 8][415:384] !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_ctr_word: got %h want 00000000", loaded[(ld0 + 1) % 8][415:384]);
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done: got %0d want 1", done_cnt); end
`endif
  endtask

  task automatic test_protocol();
    checks++; if (viol_rw != 0) begin errors++; $display("FAIL write_read_overlap: got %0d want 0", viol_rw); end
    checks++; if (viol_rd != 0) begin errors++; $display("FAIL read_before_ready: got %0d want 0", viol_rd); end
  endtask

  initial begin
    test_reset();
    test_rfc();
    test_single_byte();
    test_random_flow();
    test_two_blocks();
    test_reset_mid();
    test_ctr_wrap();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
